// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder arbiter slice.
package serial_add_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam int ID_W      = 1;
   localparam int DEFAULT_N = 4;

endpackage

// File: rtl/serial_add_arbiter_rr_arbiter2.sv
// Two-way grant logic. SERIAL_ADD_ARB_RR_EN selects round-robin; otherwise req0 has fixed priority.
module rr_arbiter2 (
   input  logic valid0,
   input  logic valid1,
`ifdef SERIAL_ADD_ARB_RR_EN
   input  logic last,
`endif
   output logic grant0,
   output logic grant1
);

`ifdef SERIAL_ADD_ARB_RR_EN
   // On contention the requester that was not served last wins.
   always_comb begin
      grant0 = valid0 & (~valid1 | last);
      grant1 = valid1 & (~valid0 | ~last);
   end
`else
   always_comb begin
      grant0 = valid0;
      grant1 = valid1 & ~valid0;
   end
`endif

endmodule

// File: rtl/serial_add_arbiter.sv
// Shares one serial_adder between two requesters; SERIAL_ADD_ARB_RR_EN enables round-robin arbitration.
module serial_add_arbiter
   import serial_add_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int LOAD_CYC = 2,
   parameter int ADD_LAT  = N
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [N-1:0]    req0_a,
   input  logic [N-1:0]    req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [N-1:0]    req1_a,
   input  logic [N-1:0]    req1_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [ID_W-1:0] rsp_id,
   output logic [N-1:0]    rsp_sum,
   output logic            rsp_cout,
   output logic [N-1:0]    add_a,
   output logic [N-1:0]    add_b,
   output logic            add_clr,
   output logic            add_load,
   input  logic [N-1:0]    add_sum,
   input  logic            add_cout
);

   localparam int CNT_MAX = (LOAD_CYC > ADD_LAT) ? LOAD_CYC : ADD_LAT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_CYC - 1);
   localparam logic [CW-1:0] RUN_INIT  = CW'(ADD_LAT - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          grant0, grant1;
   logic          accept;

`ifdef SERIAL_ADD_ARB_RR_EN
   logic last_served;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       last_served <= 1'b1;
      else if (accept) last_served <= grant1;
   end

   rr_arbiter2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last_served),
      .grant0 (grant0),
      .grant1 (grant1)
   );
`else
   rr_arbiter2 u_arb (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .grant0 (grant0),
      .grant1 (grant1)
   );
`endif

   // Ready is gated by reset so it reads 0 while reset is held, like every other output.
   assign req0_ready = (state == IDLE) & grant0 & ~reset;
   assign req1_ready = (state == IDLE) & grant1 & ~reset;
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE:  if (accept) state_nx = CLEAR;
         CLEAR: begin
            state_nx = LOAD;
            cnt_nx   = LOAD_INIT;
         end
         LOAD: begin
            if (cnt == '0) begin
               state_nx = RUN;
               cnt_nx   = RUN_INIT;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         RUN: begin
            if (cnt == '0) state_nx = DONE;
            else           cnt_nx   = cnt - CW'(1);
         end
         DONE:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Adder controls are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_clr   <= 1'b0;
         add_load  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         add_clr  <= (state_nx == CLEAR);
         add_load <= (state_nx == LOAD);
         if (accept) begin
            add_a  <= grant1 ? req1_a : req0_a;
            add_b  <= grant1 ? req1_b : req0_b;
            rsp_id <= ID_W'(grant1);
         end
         if (state == RUN && cnt == '0) begin
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_valid <= 1'b1;
         end else if (state == DONE && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter with a behavioural adder and a cycle-level reference model.
module tb_serial_add_arbiter;

   localparam int N        = 4;
   localparam int LOAD_CYC = 2;
   localparam int ADD_LAT  = 4;
   localparam int DONE_T   = 1 + LOAD_CYC + ADD_LAT;
`ifdef SERIAL_ADD_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         rsp_valid, rsp_ready = 1'b1;
   logic         rsp_id;
   logic [N-1:0] rsp_sum;
   logic         rsp_cout;
   logic [N-1:0] add_a, add_b, add_sum;
   logic         add_clr, add_load, add_cout;

   int checks = 0;
   int failures = 0;

   serial_add_arbiter #(.N(N), .LOAD_CYC(LOAD_CYC), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .add_a(add_a), .add_b(add_b), .add_clr(add_clr), .add_load(add_load),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   always #5 clk = ~clk;

   // Stand-in adder: result is only correct ADD_LAT cycles after load falls, garbage before that.
   logic [N-1:0] ad_a = '0, ad_b = '0;
   logic         ad_loaded = 1'b0;
   int           ad_cnt = 0;
   logic [N:0]   ad_res;

   always @(posedge clk) begin
      if (add_clr) begin
         ad_loaded <= 1'b0;
         ad_cnt    <= 0;
      end else if (add_load) begin
         ad_a      <= add_a;
         ad_b      <= add_b;
         ad_loaded <= 1'b1;
         ad_cnt    <= 0;
      end else if (ad_loaded && ad_cnt < 1000) begin
         ad_cnt <= ad_cnt + 1;
      end
   end

   assign ad_res = {1'b0, ad_a} + {1'b0, ad_b};
   assign {add_cout, add_sum} = (ad_loaded && ad_cnt >= ADD_LAT - 1) ? ad_res : ~ad_res;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                                input logic v1, input logic [N-1:0] a1, input logic [N-1:0] b1);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
   endtask

   function automatic logic [1:0] grant_of(input logic v0, input logic v1, input logic lst);
      if (v0 && v1) return (!RR || lst) ? 2'b01 : 2'b10;
      return {v1 & ~v0, v0};
   endfunction

   // Reference model: one operation at a time, tracked by cycles elapsed since the accept edge.
   logic         m_idle = 1'b1;
   int           m_t = 0;
   logic         m_last = 1'b1;
   logic [N-1:0] m_a = '0, m_b = '0, m_sum = '0;
   logic         m_id = 1'b0, m_cout = 1'b0;
   logic [N:0]   m_res = '0;

   always @(negedge clk) begin
      if (reset) begin
         checkOutput("reset_ctrl", {req0_ready, req1_ready, add_clr, add_load, rsp_valid, rsp_id, rsp_cout}, 0);
         checkOutput("reset_data", {rsp_sum, add_a, add_b}, 0);
         m_idle <= 1'b1; m_t <= 0; m_last <= 1'b1;
         m_a <= '0; m_b <= '0; m_sum <= '0; m_id <= 1'b0; m_cout <= 1'b0;
      end else begin
         checkOutput("ready0", req0_ready, m_idle & grant_of(req0_valid, req1_valid, m_last)[0]);
         checkOutput("ready1", req1_ready, m_idle & grant_of(req0_valid, req1_valid, m_last)[1]);
         checkOutput("add_clr", add_clr, !m_idle && m_t == 0);
         checkOutput("add_load", add_load, !m_idle && m_t >= 1 && m_t <= LOAD_CYC);
         checkOutput("rsp_valid", rsp_valid, !m_idle && m_t >= DONE_T);
         checkOutput("rsp_id", rsp_id, m_id);
         checkOutput("rsp_sum", rsp_sum, m_sum);
         checkOutput("rsp_cout", rsp_cout, m_cout);
         checkOutput("add_a", add_a, m_a);
         checkOutput("add_b", add_b, m_b);
         if (m_idle) begin
            if (grant_of(req0_valid, req1_valid, m_last) != 2'b00) begin
               m_idle <= 1'b0;
               m_t    <= 0;
               m_id   <= grant_of(req0_valid, req1_valid, m_last)[1];
               m_last <= grant_of(req0_valid, req1_valid, m_last)[1];
               m_a    <= grant_of(req0_valid, req1_valid, m_last)[1] ? req1_a : req0_a;
               m_b    <= grant_of(req0_valid, req1_valid, m_last)[1] ? req1_b : req0_b;
               m_res  <= grant_of(req0_valid, req1_valid, m_last)[1] ?
                         ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
            end
         end else begin
            if (m_t == DONE_T - 1) {m_cout, m_sum} <= m_res;
            if (m_t >= DONE_T && rsp_ready) m_idle <= 1'b1;
            else                            m_t    <= m_t + 1;
         end
      end
   end

   // One full operation with hand-computed expectations for latency, control pulses and result.
   task automatic runOp(input logic id, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] es, input logic ec);
      int  k, clr_c, load_c, rdy_c;
      bit  seen;
      @(posedge clk); #1;
      if (id) applyStimulus(0, '0, '0, 1, a, b);
      else    applyStimulus(1, a, b, 0, '0, '0);
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = id ? req1_ready : req0_ready;
      end
      checkOutput("op_accept", seen, 1);
      @(posedge clk); #1;
      applyStimulus(0, '0, '0, 0, '0, '0);
      k = 0; clr_c = 0; load_c = 0; rdy_c = 0;
      while (!rsp_valid && k < 40) begin
         @(negedge clk);
         k++;
         clr_c  += int'(add_clr);
         load_c += int'(add_load);
         rdy_c  += int'(req0_ready | req1_ready);
      end
      checkOutput("op_latency", k - 1, 7);
      checkOutput("op_clr_cycles", clr_c, 1);
      checkOutput("op_load_cycles", load_c, 2);
      checkOutput("op_extra_ready", rdy_c, 0);
      checkOutput("op_sum", rsp_sum, es);
      checkOutput("op_cout", rsp_cout, ec);
      checkOutput("op_id", rsp_id, id);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      logic [N-1:0] ra, rb;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      runOp(1'b0, 4'b1111, 4'b0111, 4'b0110, 1'b1);
      runOp(1'b1, 4'b1110, 4'b0111, 4'b0101, 1'b1);
      runOp(1'b0, 4'b0010, 4'b1001, 4'b1011, 1'b0);

      // Result held while the consumer stalls; req1 stays locked out until after the handshake.
      @(posedge clk); #1;
      applyStimulus(1, 4'b0011, 4'b0100, 0, '0, '0);
      rsp_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
      checkOutput("hold_accept", seen, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
      checkOutput("hold_rsp_seen", rsp_valid, 1);
      @(posedge clk); #1;
      applyStimulus(0, '0, '0, 1, 4'b1000, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", rsp_valid, 1);
         checkOutput("hold_sum", {rsp_cout, rsp_sum}, 5'b00111);
         checkOutput("hold_ready1", req1_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("hold_ready1_hs", req1_ready, 0);
      @(negedge clk);
      checkOutput("hold_ready1_after", req1_ready, 1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      for (int i = 0; i < 30 && !rsp_valid; i++) @(negedge clk);
      checkOutput("hold_req1_sum", {rsp_cout, rsp_sum}, 5'b10000);

      // Continuous contention after requester 1 was served last.
      @(posedge clk); #1;
      applyStimulus(1, 4'b0101, 4'b0001, 1, 4'b0110, 4'b0010);
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if (req0_ready | req1_ready) begin
            checkOutput("contend_grant", req1_ready, RR ? (n % 2) : 0);
            n++;
         end
      end
      checkOutput("contend_count", n, 4);
      @(posedge clk); #1;
      applyStimulus(0, '0, '0, 0, '0, '0);
      repeat (12) @(posedge clk);
      #1;

      // Reset in the middle of RUN drops the operation.
      applyStimulus(1, 4'b1001, 4'b1001, 0, '0, '0);
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin @(negedge clk); seen = req0_ready; end
      checkOutput("rst_accept", seen, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1 checkOutput("rst_async", {rsp_valid, add_clr, add_load, rsp_cout, rsp_id, rsp_sum, add_a, add_b}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin @(negedge clk); n += int'(rsp_valid); end
      checkOutput("rst_no_rsp", n, 0);
      runOp(1'b0, 4'b0101, 4'b0011, 4'b1000, 1'b0);

      // Randomized traffic with occasional resets and consumer stalls.
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         ra = N'($urandom); rb = N'($urandom);
         applyStimulus($urandom_range(0, 9) < 6, ra, rb, $urandom_range(0, 9) < 6, N'($urandom), N'($urandom));
         rsp_ready = $urandom_range(0, 9) < 7;
         reset = ($urandom_range(0, 199) == 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      rsp_ready = 1'b1;
      applyStimulus(0, '0, '0, 0, '0, '0);
      repeat (15) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
